// File: rtl/mmio_led_ring_ctrl.sv
// MMIO peripheral on the core's MEM-stage data port: LED/switch/done registers, switch
// synchroniser and debouncer, and a prescaled rotating LED ring started by the done flag.
module mmio_led_ring_ctrl #(
  parameter logic [31:0] LED_ADDR        = 32'hFFFF_0000,
  parameter logic [31:0] SW_ADDR         = 32'hFFFF_0004,
  parameter logic [31:0] DONE_ADDR       = 32'hFFFF_0008,
  parameter int unsigned TICK_DIV        = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  output logic        mmio_hit,
  input  logic [3:0]  switches,
  output logic [3:0]  leds,
  output logic        debug_led,
  output logic [3:0]  io_leds_reg,
  output logic        program_done,
  output logic [3:0]  led_ring,
  output logic        tick_step
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       io_leds_q, io_leds_d;
  logic             done_q, done_d;
  logic [TickW-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [3:0]       ring_q, ring_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       sw_stable_q, sw_stable_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;

  logic hit_led, hit_sw, hit_done;

  // Loads are served whenever the address matches, so the strobe carries no information here.
  logic unused_bits;
  assign unused_bits = ^{mem_re, mem_wdata[31:4]};

  assign hit_led  = (mem_addr == LED_ADDR);
  assign hit_sw   = (mem_addr == SW_ADDR);
  assign hit_done = (mem_addr == DONE_ADDR);
  assign mmio_hit = hit_led | hit_sw | hit_done;

  // Register writes; the LED register freezes once the program has signalled completion.
  always_comb begin
    io_leds_d = io_leds_q;
    if (mem_we && hit_led && !done_q) begin
      io_leds_d = mem_wdata[3:0];
    end
    done_d = done_q | (mem_we & hit_done & mem_wdata[0]);
  end

  // Prescaler and ring; the ring steps on the same edge that raises tick_step.
  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    if (done_q) begin
      if (presc_q == TickLast) begin
        tick_d = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    ring_d = ring_q;
    if (done_d && !done_q) begin
      ring_d = 4'b0001;
    end else if (tick_d) begin
      ring_d = {ring_q[2:0], ring_q[3]};
    end
  end

  // Two-flop synchroniser, then a change is accepted only after DEBOUNCE_CYCLES differing cycles.
  always_comb begin
    sync1_d     = switches;
    sync2_d     = sync1_q;
    sw_stable_d = sw_stable_q;
    db_cnt_d    = db_cnt_q;
    if (sync2_q == sw_stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      sw_stable_d = sync2_q;
      db_cnt_d    = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_leds_q   <= '0;
      done_q      <= 1'b0;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      ring_q      <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sw_stable_q <= '0;
      db_cnt_q    <= '0;
    end else begin
      io_leds_q   <= io_leds_d;
      done_q      <= done_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      ring_q      <= ring_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sw_stable_q <= sw_stable_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  // Read mux sees only registered state, so a same-cycle write returns the old value.
  always_comb begin
    mem_rdata = '0;
    if (hit_led) begin
      mem_rdata = {28'b0, io_leds_q};
    end else if (hit_sw) begin
      mem_rdata = {28'b0, sw_stable_q};
    end else if (hit_done) begin
      mem_rdata = {31'b0, done_q};
    end
  end

  assign leds         = done_q ? ring_q : io_leds_q;
  assign debug_led    = done_q;
  assign io_leds_reg  = io_leds_q;
  assign program_done = done_q;
  assign led_ring     = ring_q;
  assign tick_step    = tick_q;

  ring_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |-> $onehot(ring_q));
  tick_needs_done_a: assert property (@(posedge clk) disable iff (!rst_n)
    tick_q |-> done_q);
  done_sticky_a: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |=> done_q);

endmodule
